led_sequencer: RTL and testbench

Controller for the board's four GPIO LEDs. It debounces the four GPIO switches and uses them to select and control one of four LED display modes: switch mirror, walking-one, ping-pong and blink. Pattern steps advance on a programmable prescaler tick. It sits directly under the top-level module and drives the LED pins.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_sequencer_if.sv | 25 ++
 rtl/led_sequencer_switch_debounce.sv | 53 +++++
 rtl/led_sequencer.sv | 118 +++++++++++
 tb/tb_led_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: display modes, pattern
// start values and a one-position rotate helper.
package led_seq_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] LED_RESET       = 4'b1111;
    localparam logic [LED_W-1:0] START_SHIFT_FWD = 4'b0001;
    localparam logic [LED_W-1:0] START_SHIFT_REV = 4'b1000;
    localparam logic [LED_W-1:0] START_BOUNCE    = 4'b0001;
    localparam logic [LED_W-1:0] START_BLINK     = 4'b1111;

    // left = 1 moves the lit LED towards the MSB, wrapping at the ends.
    function automatic logic [LED_W-1:0] rotate(input logic [LED_W-1:0] v, input logic left);
        return left ? {v[LED_W-2:0], v[LED_W-1]} : {v[0], v[LED_W-1:1]};
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Board-facing GPIO bundle of the LED sequencer; master drives the switches,
// slave (the sequencer) drives LEDs, mode and the step pulse.
interface led_sequencer_if;
    import led_seq_pkg::*;

    logic [LED_W-1:0] gpio_switch;
    logic [LED_W-1:0] gpio_led;
    logic [1:0]       mode;
    logic             step_tick;

    modport master (
        output gpio_switch,
        input  gpio_led,
        input  mode,
        input  step_tick
    );

    modport slave (
        input  gpio_switch,
        output gpio_led,
        output mode,
        output step_tick
    );

endinterface

// File: rtl/led_sequencer_switch_debounce.sv
// Two-flop synchroniser followed by an independent debounce counter per bit;
// a bit only follows its input after DEBOUNCE_CYCLES consecutive differing cycles.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] r_cnt;
            logic          r_stable;

            // Any matching cycle restarts the count, so short glitches never commit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync[gi] == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync[gi];
                end else begin
                    r_cnt    <= r_cnt + CW'(1);
                end
            end

            assign o_stable[gi] = r_stable;
        end
    endgenerate

endmodule

// File: rtl/led_sequencer.sv
// Four-LED display controller: debounced switches pick mirror, walking-one,
// ping-pong or blink; pattern steps advance on a pausable prescaler tick.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic          SYSTEMCLOCK,
    input  logic          PUSH_BUTTON_RESET_RAW,
    led_sequencer_if.slave bus
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [LED_W-1:0] w_sw;
    mode_e            w_sw_mode;
    logic             w_pause;
    logic             w_rev;
    logic             w_hold;
    logic             w_tick;
    logic             w_mode_chg;

    logic [PW-1:0]    r_presc;
    mode_e            r_mode;
    logic [LED_W-1:0] r_led;
    logic             r_dir_up;

    logic [PW-1:0]    w_presc_next;
    mode_e            w_mode_next;
    logic [LED_W-1:0] w_led_next;
    logic             w_dir_up_next;

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WIDTH           (LED_W)
    ) u_debounce (
        .clk      (SYSTEMCLOCK),
        .rst_n    (PUSH_BUTTON_RESET_RAW),
        .i_raw    (bus.gpio_switch),
        .o_stable (w_sw)
    );

    assign w_sw_mode  = mode_e'(w_sw[1:0]);
    assign w_pause    = w_sw[2];
    assign w_rev      = w_sw[3];
    assign w_hold     = w_pause && (r_mode != MODE_MIRROR);
    assign w_tick     = (r_presc == TICK_LAST) && !w_hold;
    assign w_mode_chg = (w_sw_mode != r_mode);

    always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
        if (!PUSH_BUTTON_RESET_RAW) begin
            r_presc  <= '0;
            r_mode   <= MODE_MIRROR;
            r_led    <= LED_RESET;
            r_dir_up <= 1'b1;
        end else begin
            r_presc  <= w_presc_next;
            r_mode   <= w_mode_next;
            r_led    <= w_led_next;
            r_dir_up <= w_dir_up_next;
        end
    end

    always_comb begin
        w_presc_next  = r_presc;
        w_mode_next   = r_mode;
        w_led_next    = r_led;
        w_dir_up_next = r_dir_up;

        // A mode change restarts everything and swallows a coincident step.
        if (w_mode_chg) begin
            w_mode_next   = w_sw_mode;
            w_presc_next  = '0;
            w_dir_up_next = 1'b1;
            case (w_sw_mode)
                MODE_MIRROR: w_led_next = w_sw;
                MODE_SHIFT:  w_led_next = w_rev ? START_SHIFT_REV : START_SHIFT_FWD;
                MODE_BOUNCE: w_led_next = START_BOUNCE;
                MODE_BLINK:  w_led_next = START_BLINK;
                default:     w_led_next = w_sw;
            endcase
        end else begin
            if (!w_hold) begin
                w_presc_next = (r_presc == TICK_LAST) ? '0 : r_presc + PW'(1);
            end
            case (r_mode)
                MODE_MIRROR: w_led_next = w_sw;
                MODE_SHIFT: begin
                    if (w_tick) w_led_next = rotate(r_led, !w_rev);
                end
                MODE_BOUNCE: begin
                    if (w_tick) begin
                        if (r_dir_up && r_led[LED_W-1]) begin
                            w_led_next    = rotate(r_led, 1'b0);
                            w_dir_up_next = 1'b0;
                        end else if (!r_dir_up && r_led[0]) begin
                            w_led_next    = rotate(r_led, 1'b1);
                            w_dir_up_next = 1'b1;
                        end else begin
                            w_led_next    = rotate(r_led, r_dir_up);
                        end
                    end
                end
                MODE_BLINK: begin
                    if (w_tick) w_led_next = ~r_led;
                end
                default: w_led_next = r_led;
            endcase
        end
    end

    assign bus.gpio_led  = r_led;
    assign bus.mode      = r_mode;
    assign bus.step_tick = w_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: hand-derived vector table for the directed scenarios,
// then random switch/reset activity checked every cycle against a behavioural model.
module tb_led_sequencer;

    localparam int TD = 4;
    localparam int DC = 3;

    logic clk;
    logic rst_n;

    led_sequencer_if bus ();

    led_sequencer #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .SYSTEMCLOCK           (clk),
        .PUSH_BUTTON_RESET_RAW (rst_n),
        .bus                   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model: raw delay line, run-length debounce, pattern as an index.
    logic [3:0] m_dl0, m_dl1, m_deb, m_led;
    int         m_run [4];
    int         m_mode, m_cnt, m_pos, m_phase;

    task automatic model_reset();
        m_dl0 = '0; m_dl1 = '0; m_deb = '0; m_led = 4'b1111;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_mode = 0; m_cnt = 0; m_pos = 0; m_phase = 0;
    endtask

    task automatic model_step();
        logic [3:0] deb_n;
        logic       paused, tick;
        int         dmode, tri_pos;
        if (!rst_n) begin
            model_reset();
            return;
        end
        paused = m_deb[2] && (m_mode != 0);
        tick   = (m_cnt == TD - 1) && !paused;
        dmode  = int'(m_deb[1:0]);
        if (dmode != m_mode) begin
            m_mode = dmode;
            m_cnt  = 0;
            case (dmode)
                0: m_led = m_deb;
                1: begin m_pos = m_deb[3] ? 3 : 0; m_led = 4'(1 << m_pos); end
                2: begin m_phase = 0; m_led = 4'b0001; end
                default: m_led = 4'b1111;
            endcase
        end else begin
            if (!paused) m_cnt = (m_cnt + 1) % TD;
            if (m_mode == 0) begin
                m_led = m_deb;
            end else if (tick) begin
                case (m_mode)
                    1: begin
                        m_pos = m_deb[3] ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
                        m_led = 4'(1 << m_pos);
                    end
                    2: begin
                        m_phase = (m_phase + 1) % 6;
                        tri_pos = (m_phase <= 3) ? m_phase : 6 - m_phase;
                        m_led   = 4'(1 << tri_pos);
                    end
                    default: m_led = ~m_led;
                endcase
            end
        end
        deb_n = m_deb;
        for (int b = 0; b < 4; b++) begin
            if (m_dl1[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DC) begin
                    deb_n[b] = m_dl1[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_dl1 = m_dl0;
        m_dl0 = bus.gpio_switch;
        m_deb = deb_n;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        logic       exp_tick;
        logic [6:0] act, exp;
        exp_tick = (m_cnt == TD - 1) && !(m_deb[2] && (m_mode != 0));
        act = {bus.gpio_led, bus.mode, bus.step_tick};
        exp = {m_led, 2'(m_mode), exp_tick};
        check("model{led,mode,tick}", {1'b0, act}, {1'b0, exp});
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            check_model();
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] sw;
        int         waits;
        logic [3:0] led;
        logic [1:0] mode;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] sw, input int w,
                       input logic [3:0] led, input logic [1:0] md, input logic tk);
        vec_t v;
        v.rst_n = r; v.sw = sw; v.waits = w; v.led = led; v.mode = md; v.tick = tk;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.gpio_switch = 4'b0000;
        model_reset();

        // reset and release
        add(0, 4'b0000, 2, 4'b1111, 2'd0, 0);
        add(1, 4'b0000, 1, 4'b0000, 2'd0, 0);
        // MIRROR: debounce latency, then a 2-cycle glitch that must not commit
        add(1, 4'b1100, 4, 4'b0000, 2'd0, 0);
        add(1, 4'b1100, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b1100, 1, 4'b1100, 2'd0, 1);
        add(1, 4'b0100, 2, 4'b1100, 2'd0, 0);
        add(1, 4'b1100, 6, 4'b1100, 2'd0, 1);
        // SHIFT forward, then reverse sampled at each step
        add(1, 4'b0001, 6, 4'b0001, 2'd1, 0);
        add(1, 4'b0001, 3, 4'b0001, 2'd1, 1);
        add(1, 4'b0001, 1, 4'b0010, 2'd1, 0);
        add(1, 4'b0001, 4, 4'b0100, 2'd1, 0);
        add(1, 4'b0001, 4, 4'b1000, 2'd1, 0);
        add(1, 4'b0001, 4, 4'b0001, 2'd1, 0);
        add(1, 4'b1001, 4, 4'b0010, 2'd1, 0);
        add(1, 4'b1001, 4, 4'b0001, 2'd1, 0);
        add(1, 4'b1001, 4, 4'b1000, 2'd1, 0);
        add(1, 4'b1001, 4, 4'b0100, 2'd1, 0);
        // BOUNCE
        add(1, 4'b0010, 6, 4'b0001, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0010, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0100, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b1000, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0100, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0010, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0001, 2'd2, 0);
        add(1, 4'b0010, 4, 4'b0010, 2'd2, 0);
        // BLINK with pause and resume
        add(1, 4'b0011, 6, 4'b1111, 2'd3, 0);
        add(1, 4'b0011, 4, 4'b0000, 2'd3, 0);
        add(1, 4'b0011, 2, 4'b0000, 2'd3, 0);
        add(1, 4'b0111, 5, 4'b1111, 2'd3, 0);
        add(1, 4'b0111, 6, 4'b1111, 2'd3, 0);
        add(1, 4'b0011, 4, 4'b1111, 2'd3, 0);
        add(1, 4'b0011, 1, 4'b1111, 2'd3, 1);
        add(1, 4'b0011, 1, 4'b0000, 2'd3, 0);
        // SHIFT -> BLINK change landing on the tick cycle
        add(1, 4'b0001, 6, 4'b0001, 2'd1, 0);
        add(1, 4'b0001, 2, 4'b0001, 2'd1, 0);
        add(1, 4'b0011, 5, 4'b0010, 2'd1, 1);
        add(1, 4'b0011, 1, 4'b1111, 2'd3, 0);
        add(1, 4'b0011, 3, 4'b1111, 2'd3, 1);
        add(1, 4'b0011, 1, 4'b0000, 2'd3, 0);
        add(1, 4'b0011, 2, 4'b0000, 2'd3, 0);
        // asynchronous reset mid-pattern, then restart
        add(0, 4'b0011, 0, 4'b1111, 2'd0, 0);
        add(0, 4'b0011, 2, 4'b1111, 2'd0, 0);
        add(1, 4'b0011, 1, 4'b0000, 2'd0, 0);
        add(1, 4'b0011, 4, 4'b0000, 2'd0, 0);
        add(1, 4'b0011, 1, 4'b1111, 2'd3, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            bus.gpio_switch = vecs[i].sw;
            if (vecs[i].waits == 0) #1;
            else run_cycles(vecs[i].waits);
            check($sformatf("row%0d_led", i),  {4'b0, bus.gpio_led}, {4'b0, vecs[i].led});
            check($sformatf("row%0d_mode", i), {6'b0, bus.mode},     {6'b0, vecs[i].mode});
            check($sformatf("row%0d_tick", i), {7'b0, bus.step_tick}, {7'b0, vecs[i].tick});
            $display("row %0d: rst_n=%b sw=%b led=%b mode=%0d tick=%b",
                     i, vecs[i].rst_n, vecs[i].sw, bus.gpio_led, bus.mode, bus.step_tick);
        end

        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                run_cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            bus.gpio_switch = 4'($urandom_range(0, 15));
            run_cycles($urandom_range(1, 14));
            $display("rand %0d: sw=%b led=%b mode=%0d", s, bus.gpio_switch, bus.gpio_led, bus.mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
